// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter, drives the instruction memory word
// address, tracks the single outstanding read and buffers returned
// instructions (with their PCs) in a small FIFO in front of decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  localparam int          PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int          CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   pc_reg;
  logic          inflight_reg;
  logic [31:0]   inflight_pc_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   instr_mem [BUF_DEPTH];
  logic [31:0]   pc_mem    [BUF_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  // Pointer advance with wrap, valid for non power-of-two depths too.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake and credit decisions: only fetch when the FIFO is sure to have
  // room for the response, counting the read already in flight.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = inflight_reg && !redirect_valid;
    occupancy = {1'b0, count_reg} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);
    issue     = !redirect_valid && (occupancy < DEPTH_C);
  end

  assign imem_address    = pc_reg >> 2;
  assign out_valid       = (count_reg != '0);
  assign out_instruction = instr_mem[rd_ptr_reg];
  assign out_pc          = pc_mem[rd_ptr_reg];

  // Program counter: redirect wins, otherwise advance by one word per issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= START_PC;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc & 32'hFFFF_FFFC;
    end else if (issue) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  // Outstanding-read tracker: memory data is only kept the cycle after an issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect discards everything buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: capture the memory response together with its PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_reg] <= imem_instruction;
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

endmodule
